// File: rtl/ysyx_25020047_seq_ctrl.sv
// ---------------------------------------------------------------------------
// ysyx_25020047_seq_ctrl
//
// Multi-cycle instruction sequencer for the NPC core. One instruction is in
// flight at a time:
//   IDLE -> FETCH -> WAIT_INST -> EXEC -> [MEM -> WAIT_MEM] -> WB -> FETCH
// Any protocol failure (illegal decode, response timeout) parks the
// sequencer in HALT until reset.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   ifu_req_valid  o    fetch request; the address is pc
//   ifu_req_ready  i    IFU accepts the fetch request
//   ifu_rsp_valid  i    instruction word valid (1-cycle pulse)
//   inst_latch_en  o    pulse: IR captures the IFU response
//   inst_type      i    one-hot decode of the latched instruction
//   dnpc           i    next PC computed by the WBU
//   pc             o    current PC register
//   lsu_req_valid  o    memory request
//   lsu_req_we     o    1 = store, 0 = load; stable while lsu_req_valid
//   lsu_req_ready  i    LSU accepts the memory request
//   lsu_rsp_valid  i    load data / store ack (1-cycle pulse)
//   rf_wen         o    GPR write enable (1-cycle pulse in WB)
//   csr_wen        o    CSR write enable (1-cycle pulse in WB)
//   commit         o    instruction retired (1-cycle pulse in WB)
//   halt           o    sticky halt flag
//   halt_code      o    0 none, 1 illegal inst_type, 2 IFU timeout,
//                       3 LSU timeout
// ---------------------------------------------------------------------------
module ysyx_25020047_seq_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h8000_0000,
  parameter logic [63:0] LOAD_MASK  = 64'h0000_00E0_0000_0060,
  parameter logic [63:0] STORE_MASK = 64'h0000_0000_0000_0184,
  parameter logic [63:0] NO_WB_MASK = 64'h0000_0100_F000_C184,
  parameter logic [63:0] CSR_MASK   = 64'h0000_0600_0000_0000,
  parameter int unsigned TIMEOUT    = 1023
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        ifu_req_valid,
  input  logic        ifu_req_ready,
  input  logic        ifu_rsp_valid,
  output logic        inst_latch_en,
  input  logic [63:0] inst_type,
  input  logic [31:0] dnpc,
  output logic [31:0] pc,
  output logic        lsu_req_valid,
  output logic        lsu_req_we,
  input  logic        lsu_req_ready,
  input  logic        lsu_rsp_valid,
  output logic        rf_wen,
  output logic        csr_wen,
  output logic        commit,
  output logic        halt,
  output logic [1:0]  halt_code
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT_INST,
    S_EXEC,
    S_MEM,
    S_WAIT_MEM,
    S_WB,
    S_HALT
  } state_e;

  typedef enum logic [1:0] {
    HC_NONE    = 2'd0,
    HC_ILLEGAL = 2'd1,
    HC_IFU_TO  = 2'd2,
    HC_LSU_TO  = 2'd3
  } halt_code_e;

  localparam int unsigned CNT_W     = 10;
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  halt_code_e       code_q, code_d;
  logic             store_q, store_d;

  // ---------------------------------------------------------------------------
  // Decode of the latched instruction class
  // ---------------------------------------------------------------------------
  logic is_onehot;
  logic is_mem;
  logic is_store;
  logic no_wb;
  logic is_csr;

  // x & (x-1) clears the lowest set bit; zero afterwards means at most one bit.
  assign is_onehot = (inst_type != 64'd0) &&
                     ((inst_type & (inst_type - 64'd1)) == 64'd0);
  assign is_mem    = |(inst_type & (LOAD_MASK | STORE_MASK));
  assign is_store  = |(inst_type & STORE_MASK);
  assign no_wb     = |(inst_type & NO_WB_MASK);
  assign is_csr    = |(inst_type & CSR_MASK);

  // ---------------------------------------------------------------------------
  // Shared wait counter: saturates at all-ones instead of wrapping, so a stuck
  // counter can never alias back to a small value and mask a timeout.
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_inc;
  logic             timeout_hit;

  assign cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
  // Timeout fires in the cycle the counter reaches TIMEOUT; a response in that
  // same cycle is checked first and therefore wins.
  assign timeout_hit = (cnt_inc == TIMEOUT_C);

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first; a path that leaves
    // one unassigned would infer a latch. Combinational blocks use blocking '='.
    state_d       = state_q;
    pc_d          = pc_q;
    cnt_d         = cnt_q;
    code_d        = code_q;
    store_d       = store_q;
    ifu_req_valid = 1'b0;
    inst_latch_en = 1'b0;
    lsu_req_valid = 1'b0;
    lsu_req_we    = 1'b0;
    rf_wen        = 1'b0;
    csr_wen       = 1'b0;
    commit        = 1'b0;
    halt          = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end

      S_FETCH: begin
        // Request held until accepted; the counter does not run here.
        ifu_req_valid = 1'b1;
        if (ifu_req_ready) begin
          state_d = S_WAIT_INST;
          cnt_d   = '0;
        end
      end

      S_WAIT_INST: begin
        if (ifu_rsp_valid) begin
          inst_latch_en = 1'b1;
          state_d       = S_EXEC;
        end else begin
          cnt_d = cnt_inc;
          if (timeout_hit) begin
            state_d = S_HALT;
            code_d  = HC_IFU_TO;
          end
        end
      end

      S_EXEC: begin
        // IDU/EXU/WBU have had one cycle to settle on the latched instruction.
        if (!is_onehot) begin
          state_d = S_HALT;
          code_d  = HC_ILLEGAL;
        end else if (is_mem) begin
          state_d = S_MEM;
          store_d = is_store;
        end else begin
          state_d = S_WB;
        end
      end

      S_MEM: begin
        // Direction comes from a register so it cannot glitch while valid.
        lsu_req_valid = 1'b1;
        lsu_req_we    = store_q;
        if (lsu_req_ready) begin
          state_d = S_WAIT_MEM;
          cnt_d   = '0;
        end
      end

      S_WAIT_MEM: begin
        if (lsu_rsp_valid) begin
          state_d = S_WB;
        end else begin
          cnt_d = cnt_inc;
          if (timeout_hit) begin
            state_d = S_HALT;
            code_d  = HC_LSU_TO;
          end
        end
      end

      S_WB: begin
        // ecall needs nothing special: dnpc already carries mtvec.
        commit  = 1'b1;
        rf_wen  = !no_wb;
        csr_wen = is_csr;
        pc_d    = dnpc;
        state_d = S_FETCH;
      end

      S_HALT: begin
        // Absorbing: no requests, no enables, pc and halt_code frozen.
        halt = 1'b1;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking '<=' so every register samples
    // the pre-edge values of the others.
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
      code_q  <= HC_NONE;
      store_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      store_q <= store_d;
    end
  end

  assign pc        = pc_q;
  assign halt_code = code_q;

endmodule

// File: tb/tb_ysyx_25020047_seq_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for ysyx_25020047_seq_ctrl.
// A driver process plays IFU, decoder/WBU and LSU from a program queue; a
// reference model turns each issued instruction into its expected retirement
// record; a monitor compares every commit and LSU handshake against it.
// ---------------------------------------------------------------------------
module tb_ysyx_25020047_seq_ctrl;

  localparam logic [31:0] RESET_PC   = 32'h8000_0000;
  localparam logic [63:0] LOAD_MASK  = 64'h0000_00E0_0000_0060;
  localparam logic [63:0] STORE_MASK = 64'h0000_0000_0000_0184;
  localparam logic [63:0] NO_WB_MASK = 64'h0000_0100_F000_C184;
  localparam logic [63:0] CSR_MASK   = 64'h0000_0600_0000_0000;
  localparam int          TIMEOUT    = 1023;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ifu_req_valid, ifu_req_ready;
  logic        ifu_rsp_valid, inst_latch_en;
  logic [63:0] inst_type;
  logic [31:0] dnpc, pc;
  logic        lsu_req_valid, lsu_req_we, lsu_req_ready, lsu_rsp_valid;
  logic        rf_wen, csr_wen, commit, halt;
  logic [1:0]  halt_code;

  always #5 clk = ~clk;

  ysyx_25020047_seq_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ifu_req_valid (ifu_req_valid),
    .ifu_req_ready (ifu_req_ready),
    .ifu_rsp_valid (ifu_rsp_valid),
    .inst_latch_en (inst_latch_en),
    .inst_type     (inst_type),
    .dnpc          (dnpc),
    .pc            (pc),
    .lsu_req_valid (lsu_req_valid),
    .lsu_req_we    (lsu_req_we),
    .lsu_req_ready (lsu_req_ready),
    .lsu_rsp_valid (lsu_rsp_valid),
    .rf_wen        (rf_wen),
    .csr_wen       (csr_wen),
    .commit        (commit),
    .halt          (halt),
    .halt_code     (halt_code)
  );

  // One instruction as the environment will serve it, with handshake delays.
  typedef struct {
    logic [63:0] inst;
    logic [31:0] dnpc;
    int          ifu_rdy;
    int          ifu_rsp;
    int          lsu_rdy;
    int          lsu_rsp;
  } instr_t;

  typedef struct {
    logic [31:0] pc;
    logic        rf;
    logic        csr;
  } commit_t;

  instr_t      prog_q[$];
  commit_t     exp_q[$];
  bit          exp_we_q[$];
  logic [31:0] model_pc = RESET_PC;
  int          n_checks = 0;
  int          n_err = 0;
  int          n_commits = 0;
  bit          drv_en = 1'b1;
  bit          inject_lsu_rsp = 1'b0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic instr_t mk(logic [63:0] inst, logic [31:0] npc,
                                int ir, int is, int lr, int ls);
    instr_t t;
    t.inst = inst; t.dnpc = npc;
    t.ifu_rdy = ir; t.ifu_rsp = is; t.lsu_rdy = lr; t.lsu_rsp = ls;
    return t;
  endfunction

  // Reference model: what retiring this instruction must look like.
  function automatic void model_issue(instr_t t);
    commit_t c;
    if ($countones(t.inst) != 1) return;  // illegal: halts, never retires
    c.pc  = model_pc;
    c.rf  = ((t.inst & NO_WB_MASK) == 64'd0);
    c.csr = ((t.inst & CSR_MASK) != 64'd0);
    exp_q.push_back(c);
    if ((t.inst & (LOAD_MASK | STORE_MASK)) != 64'd0)
      exp_we_q.push_back((t.inst & STORE_MASK) != 64'd0);
    model_pc = t.dnpc;
  endfunction

  // ---------------------------------------------------------------------------
  // Environment driver: acts 1 time unit after each rising edge.
  // ---------------------------------------------------------------------------
  typedef enum {P_IDLE, P_REQ, P_RSP} phase_e;

  initial begin
    phase_e ip, lp;
    int     icnt, lcnt;
    instr_t cur;
    ip = P_IDLE; lp = P_IDLE; icnt = 0; lcnt = 0;
    cur = mk(64'd0, 32'd0, 0, 0, 0, 0);
    ifu_req_ready = 1'b0; ifu_rsp_valid = 1'b0;
    lsu_req_ready = 1'b0; lsu_rsp_valid = 1'b0;
    inst_type = 64'd0; dnpc = 32'd0;
    forever begin
      @(posedge clk); #1;
      ifu_req_ready = 1'b0; ifu_rsp_valid = 1'b0;
      lsu_req_ready = 1'b0; lsu_rsp_valid = 1'b0;
      if (!rst_n) begin
        ip = P_IDLE; lp = P_IDLE;
      end else if (!drv_en) begin
        lsu_rsp_valid = inject_lsu_rsp;
      end else begin
        if (ip == P_IDLE && ifu_req_valid && prog_q.size() > 0) begin
          cur  = prog_q.pop_front();
          icnt = cur.ifu_rdy;
          ip   = P_REQ;
        end
        if (ip == P_REQ) begin
          if (icnt == 0) begin
            ifu_req_ready = 1'b1; ip = P_RSP; icnt = cur.ifu_rsp;
          end else icnt--;
        end else if (ip == P_RSP) begin
          if (icnt == 0) begin
            ifu_rsp_valid = 1'b1;
            inst_type     = cur.inst;
            dnpc          = cur.dnpc;
            model_issue(cur);
            ip = P_IDLE;
          end else icnt--;
        end
        if (lp == P_IDLE && lsu_req_valid) begin
          lcnt = cur.lsu_rdy; lp = P_REQ;
        end
        if (lp == P_REQ) begin
          if (lcnt == 0) begin
            lsu_req_ready = 1'b1; lp = P_RSP; lcnt = cur.lsu_rsp;
          end else lcnt--;
        end else if (lp == P_RSP) begin
          if (lcnt == 0) begin
            lsu_rsp_valid = 1'b1; lp = P_IDLE;
          end else lcnt--;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor: samples on the falling edge, pops the scoreboard on DUT events.
  // ---------------------------------------------------------------------------
  initial begin
    commit_t e;
    bit      we;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("stray_wen", {62'd0, rf_wen & ~commit, csr_wen & ~commit}, 64'd0);
        if (commit) begin
          n_commits++;
          check("commit_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("commit_pc", pc, e.pc);
            check("commit_rf_wen", rf_wen, e.rf);
            check("commit_csr_wen", csr_wen, e.csr);
          end
        end
        if (lsu_req_valid && lsu_req_ready) begin
          check("lsu_expected", exp_we_q.size() != 0, 1);
          if (exp_we_q.size() != 0) begin
            we = exp_we_q.pop_front();
            check("lsu_req_we", lsu_req_we, we);
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic do_reset();
    @(posedge clk); #3;
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_pc", pc, RESET_PC);
    check("rst_outputs", {ifu_req_valid, inst_latch_en, lsu_req_valid, lsu_req_we,
                          rf_wen, csr_wen, commit, halt, halt_code}, 64'd0);
    @(posedge clk);
    prog_q.delete(); exp_q.delete(); exp_we_q.delete();
    model_pc = RESET_PC;
    #3 rst_n = 1'b1;
  endtask

  // Runs one instruction to commit, counting handshake activity on the way.
  task automatic run_one(instr_t t, output bit got, output int nv,
                         output int nwe, output int nrf);
    got = 1'b0; nv = 0; nwe = 0; nrf = 0;
    prog_q.push_back(t);
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (lsu_req_valid) begin nv++; nwe += int'(lsu_req_we); end
      if (rf_wen) nrf++;
      if (commit) got = 1'b1;
    end
  endtask

  task automatic wait_halt(int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (halt) got = 1'b1;
    end
  endtask

  task automatic wait_ifu_accept(output bit got);
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (ifu_req_valid && ifu_req_ready) got = 1'b1;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    bit          got;
    int          nv, nwe, nrf, n, target;
    logic [63:0] pick[8];
    logic [31:0] frozen_pc;

    pick = '{64'h1, 64'h20, 64'h40, 64'h4, 64'h80, 64'h4000,
             64'h200_0000_0000, 64'h100_0000_0000};

    // Basic latency: addi with IFU ready and a response one cycle later.
    do_reset();
    prog_q.push_back(mk(64'h1, 32'h8000_0004, 0, 0, 0, 0));
    @(negedge clk); check("c0_ifu_req", ifu_req_valid, 0);
    @(negedge clk); check("c1_ifu_req", ifu_req_valid, 1);
    @(negedge clk); check("c2_latch", inst_latch_en, 1);
    @(negedge clk); check("c3_commit", commit, 0);
    @(negedge clk); check("c4_commit", commit, 1);
    check("c4_rf_wen", rf_wen, 1);
    @(negedge clk); check("c5_pc", pc, 32'h8000_0004);
    check("c5_ifu_req", ifu_req_valid, 1);

    // Load: LSU ready delayed 3 cycles, response 2 cycles after acceptance.
    run_one(mk(64'h20, 32'h8000_0100, 0, 0, 3, 1), got, nv, nwe, nrf);
    check("ld_commit", got, 1);
    check("ld_valid_cycles", nv, 4);
    check("ld_we_cycles", nwe, 0);
    check("ld_rf_pulses", nrf, 1);

    // Store: lsu_req_we high through MEM, no GPR write.
    run_one(mk(64'h4, 32'h8000_0200, 1, 1, 0, 0), got, nv, nwe, nrf);
    check("st_commit", got, 1);
    check("st_we_cycles", nwe, nv);
    check("st_valid_cycles", nv, 1);
    check("st_rf_pulses", nrf, 0);

    // Branch: no GPR write, pc follows dnpc.
    run_one(mk(64'h4000, 32'h8000_0080, 0, 2, 0, 0), got, nv, nwe, nrf);
    check("br_commit", got, 1);
    check("br_rf_pulses", nrf, 0);
    @(negedge clk); check("br_pc", pc, 32'h8000_0080);

    // csrrw: GPR and CSR written in the same WB cycle.
    prog_q.push_back(mk(64'h200_0000_0000, 32'h8000_0084, 0, 0, 0, 0));
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (commit) begin
        got = 1'b1;
        check("csr_rf_csr", {rf_wen, csr_wen}, 2'b11);
      end
    end
    check("csr_commit", got, 1);

    // Randomized legal instructions with random handshake delays.
    target = n_commits + 60;
    for (int i = 0; i < 60; i++) begin
      logic [63:0] it;
      if ($urandom_range(0, 1) == 0) it = pick[$urandom_range(0, 7)];
      else it = 64'd1 << $urandom_range(0, 63);
      prog_q.push_back(mk(it, $urandom & 32'hFFFF_FFFC,
                          $urandom_range(0, 3), $urandom_range(0, 3),
                          $urandom_range(0, 3), $urandom_range(0, 3)));
    end
    for (int i = 0; i < 3000 && n_commits < target; i++) @(negedge clk);
    check("rand_commits", n_commits, target);

    // inst_type == 0: permanent halt with code 1, pc frozen.
    frozen_pc = model_pc;
    prog_q.push_back(mk(64'd0, 32'h1234_5678, 0, 0, 0, 0));
    wait_halt(40, got);
    check("ill0_halt", got, 1);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n += int'(ifu_req_valid | lsu_req_valid | commit);
    end
    check("ill0_quiet", n, 0);
    check("ill0_code", {halt, halt_code}, 3'b101);
    check("ill0_pc", pc, frozen_pc);

    // Not one-hot: also illegal.
    do_reset();
    prog_q.push_back(mk(64'h3, 32'h8000_0010, 0, 0, 0, 0));
    wait_halt(40, got);
    check("ill2_halt", got, 1);
    check("ill2_code", halt_code, 1);
    check("ill2_pc", pc, RESET_PC);

    // IFU never responds: halt exactly TIMEOUT cycles after acceptance.
    do_reset();
    prog_q.push_back(mk(64'h1, 32'h8000_0004, 0, 5000, 0, 0));
    wait_ifu_accept(got);
    check("ifu_to_accept", got, 1);
    n = 0;
    for (int i = 0; i < TIMEOUT + 20; i++) begin
      @(negedge clk);
      if (halt) break;
      n++;
    end
    check("ifu_to_cycles", n, TIMEOUT);
    check("ifu_to_code", halt_code, 2);

    // Response in the very cycle the counter reaches TIMEOUT wins.
    do_reset();
    run_one(mk(64'h1, 32'h8000_1000, 0, TIMEOUT - 1, 0, 0), got, nv, nwe, nrf);
    if (!got) for (int i = 0; i < TIMEOUT && !commit; i++) @(negedge clk);
    check("ifu_edge_commit", commit, 1);
    check("ifu_edge_no_halt", halt, 0);

    // LSU never responds: halt with code 3.
    do_reset();
    prog_q.push_back(mk(64'h20, 32'h8000_0004, 0, 0, 0, 5000));
    wait_halt(TIMEOUT + 40, got);
    check("lsu_to_halt", got, 1);
    check("lsu_to_code", halt_code, 3);

    // Reset in the middle of WAIT_MEM; a late LSU response is ignored.
    do_reset();
    prog_q.push_back(mk(64'h40, 32'h8000_0044, 0, 0, 1, 30));
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (lsu_req_valid && lsu_req_ready) got = 1'b1;
    end
    check("mid_lsu_accept", got, 1);
    repeat (3) @(negedge clk);
    drv_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_pc", pc, RESET_PC);
    check("mid_rst_outputs", {lsu_req_valid, lsu_req_we, commit, halt, ifu_req_valid},
          64'd0);
    repeat (2) @(posedge clk);
    prog_q.delete(); exp_q.delete(); exp_we_q.delete();
    model_pc = RESET_PC;
    #3 rst_n = 1'b1;
    n = n_commits;
    @(posedge clk); #3 inject_lsu_rsp = 1'b1;
    @(posedge clk); #3 inject_lsu_rsp = 1'b0;
    repeat (8) @(negedge clk);
    check("late_rsp_no_commit", n_commits, n);
    check("late_rsp_state", {halt, lsu_req_valid, ifu_req_valid}, 3'b001);
    check("late_rsp_pc", pc, RESET_PC);
    drv_en = 1'b1;
    run_one(mk(64'h1, 32'h8000_0008, 0, 0, 0, 0), got, nv, nwe, nrf);
    check("post_rst_commit", got, 1);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/ysyx_25020047_seq_ctrl.md
Name: ysyx_25020047_seq_ctrl

Overview:
Multi-cycle instruction sequencer for the NPC core. It fetches through a valid/ready IFU port and waits for the instruction response. It holds each instruction in EXEC for one cycle so IDU/EXU/WBU can settle, then optionally runs a load/store through the LSU port. It commits by pulsing PC update, GPR write enable and CSR write enable, using the one-hot inst_type and the WBU's dnpc.

Parameters:
RESET_PC, 32'h8000_0000, PC value loaded on reset
LOAD_MASK, 64'h0000_00E0_0000_0060, inst_type bits that are loads (lw, lbu, lb, lh, lhu)
STORE_MASK, 64'h0000_0000_0000_0184, inst_type bits that are stores (sw, sh, sb)
NO_WB_MASK, 64'h0000_0100_F000_C184, bits with no GPR write (stores, branches, ecall)
CSR_MASK, 64'h0000_0600_0000_0000, bits that write a CSR (csrrw, csrrs)
TIMEOUT, 1023, max cycles waiting for any response before halting

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
ifu_req_valid  out  1  fetch request, address = pc
ifu_req_ready  in  1  IFU accepts request
ifu_rsp_valid  in  1  instruction word valid (1-cycle pulse)
inst_latch_en  out  1  pulse: IR captures the IFU response
inst_type  in  64  one-hot decode of the latched instruction
dnpc  in  32  next PC from WBU
pc  out  32  current PC register
lsu_req_valid  out  1  memory request
lsu_req_we  out  1  1 = store, 0 = load; stable while lsu_req_valid
lsu_req_ready  in  1  LSU accepts request
lsu_rsp_valid  in  1  load data / store ack (1-cycle pulse)
rf_wen  out  1  GPR write enable (1-cycle pulse)
csr_wen  out  1  CSR write enable (1-cycle pulse)
commit  out  1  instruction retired (1-cycle pulse)
halt  out  1  sticky halt flag
halt_code  out  2  0 none, 1 illegal inst_type, 2 IFU timeout, 3 LSU timeout

Behaviour:
- Reset (async assert, sync release): state=IDLE, pc=RESET_PC, wait counter=0. All other outputs 0.
- IDLE: goes to FETCH on the next cycle.
- FETCH: ifu_req_valid=1. On ifu_req_ready go to WAIT_INST and clear the counter. Request stays high until accepted; the counter does not run in FETCH.
- WAIT_INST: ifu_rsp_valid produces inst_latch_en=1 in the same cycle, then EXEC.
  - Counter increments each cycle without a response.
  - Counter reaching TIMEOUT goes to HALT with code 2.
  - A response in the same cycle the counter reaches TIMEOUT wins.
- EXEC: one cycle; the decision uses inst_type.
  - inst_type==0 or not one-hot: HALT with code 1.
  - LOAD_MASK|STORE_MASK hit: go to MEM; lsu_req_we = STORE_MASK hit.
  - Otherwise: go to WB.
- MEM: lsu_req_valid=1, held until lsu_req_ready, then WAIT_MEM with the counter cleared.
- WAIT_MEM: lsu_rsp_valid goes to WB. TIMEOUT goes to HALT with code 3.
- WB: one cycle.
  - commit=1; pc<=dnpc at the clock edge.
  - rf_wen=1 unless inst_type hits NO_WB_MASK.
  - csr_wen=1 on a CSR_MASK hit.
  - Then FETCH.
- HALT: absorbing. halt=1 and halt_code hold until reset; no requests, no enables, pc frozen.
- Unsolicited pulses: ifu_rsp_valid outside WAIT_INST and lsu_rsp_valid outside WAIT_MEM are ignored.
- Latency: non-memory instruction with ready=1 and response the cycle after acceptance takes 4 cycles (FETCH, WAIT_INST, EXEC, WB). Memory instruction under the same conditions takes 6 cycles.
- Counter is 10 bits, saturating; it never wraps.
- Reset mid-transaction: outstanding requests drop in the reset cycle. Any response arriving after release is ignored by the unsolicited-pulse rule.
- ecall: not special here. dnpc already carries mtvec from the WBU; no GPR write.

Test Plan:
- Reset release, IFU always ready, rsp 1 cycle later, inst_type=64'h1 (addi), dnpc=32'h8000_0004:
  - ifu_req_valid high in cycle 1.
  - commit and rf_wen in cycle 4; pc=32'h8000_0004 in cycle 5.
  - Next ifu_req_valid in cycle 5.
- Load inst_type=64'h20, lsu_req_ready delayed 3 cycles, rsp 2 cycles after acceptance:
  - lsu_req_valid held high for 4 cycles with lsu_req_we=0.
  - rf_wen pulses exactly once in WB.
- Store inst_type=64'h4:
  - lsu_req_we=1 through MEM.
  - commit=1 with rf_wen=0.
  - Branch inst_type=64'h4000 likewise gives rf_wen=0 with pc=dnpc.
- csrrw inst_type=64'h200_0000_0000: rf_wen=1 and csr_wen=1 in the same WB cycle.
- inst_type=0 in EXEC gives halt=1 and halt_code=1 permanently; no further ifu_req_valid.
- Timeouts and reset:
  - IFU never responds: halt_code=2 exactly TIMEOUT cycles after acceptance.
  - rst_n pulsed low mid WAIT_MEM: outputs clear immediately; pc=RESET_PC; a late lsu_rsp_valid is ignored.
